// File: rtl/transpose_pkg.sv
// transpose_pkg: shared encodings and element-geometry helpers for tile_transpose
package transpose_pkg;
  typedef enum logic [1:0] {M_B1 = 2'd0, M_B2 = 2'd1, M_B4 = 2'd2, M_RSV = 2'd3} mode_e;
  typedef enum logic [1:0] {B_EMPTY, B_FILL, B_FULL, B_DRAIN} bank_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_e;
  function automatic int unsigned elem_bytes(input mode_e m);
    return 32'd1 << m;
  endfunction
  function automatic int unsigned n_elems(input int unsigned buffd, input mode_e m);
    return buffd >> m;
  endfunction
endpackage

// File: rtl/transpose_bank.sv
// transpose_bank: one tile of row storage with a column read mux selected by element size
module transpose_bank import transpose_pkg::*; #(
  parameter int BUFFD = 64
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(BUFFD)-1:0] wr_row,
  input  logic [BUFFD*8-1:0]       wr_data,
  input  mode_e                    mode,
  input  logic [$clog2(BUFFD)-1:0] rd_col,
  output logic [BUFFD*8-1:0]       rd_data
);
  logic [BUFFD*8-1:0] mem [BUFFD];
  logic [BUFFD*8-1:0] c1, c2, c4;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_row] <= wr_data;
  // column index is masked to the element count so unused modes never index past the row
  always_comb begin
    c1 = '0;
    c2 = '0;
    c4 = '0;
    for (int r = 0; r < BUFFD; r++)
      c1[r*8 +: 8] = mem[r][int'(rd_col)*8 +: 8];
    for (int r = 0; r < BUFFD/2; r++)
      c2[r*16 +: 16] = mem[r][(int'(rd_col) & (BUFFD/2-1))*16 +: 16];
    for (int r = 0; r < BUFFD/4; r++)
      c4[r*32 +: 32] = mem[r][(int'(rd_col) & (BUFFD/4-1))*32 +: 32];
    rd_data = mode == M_B4 ? c4 : mode == M_B2 ? c2 : c1;
  end
endmodule

// File: rtl/tile_transpose.sv
// tile_transpose: streaming tile transposer, rows in, columns out, via two ping-pong banks
module tile_transpose import transpose_pkg::*; #(
  parameter int BUFFD = 64,
  parameter int CW    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [CW-1:0]      tile_num,
  input  logic [BUFFD*8-1:0] in_data,
  input  logic               in_vld,
  output logic               in_rdy,
  output logic [BUFFD*8-1:0] out_data,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic               busy,
  output logic               finish,
  output logic               cfg_err
);
  localparam int RW = $clog2(BUFFD);
  fsm_e state_q, state_d;
  mode_e mode_q, mode_d;
  logic [CW-1:0] tnum_q, tnum_d, in_tiles_q, in_tiles_d, out_tiles_q, out_tiles_d;
  logic pend_q, pend_d, cfg_err_q, cfg_err_d;
  logic fill_sel_q, fill_sel_d, ld_sel_q, ld_sel_d;
  logic out_bank_q, out_bank_d, out_last_q, out_last_d, out_vld_q, out_vld_d;
  logic [RW-1:0] wr_row_q, wr_row_d, ld_col_q, ld_col_d, n_m1;
  logic [BUFFD*8-1:0] out_data_q, out_data_d;
  bank_e bank_q [2];
  bank_e bank_d [2];
  logic [BUFFD*8-1:0] rd_data [2];
  logic in_acc, out_acc, rel, fill_ok, ld_ok, wr_last, ld_last;

  for (genvar i = 0; i < 2; i++) begin : g_bank
    transpose_bank #(.BUFFD(BUFFD)) u_bank (
      .clk    (clk),
      .wr_en  (in_acc && fill_sel_q == 1'(i)),
      .wr_row (wr_row_q),
      .wr_data(in_data),
      .mode   (mode_q),
      .rd_col (ld_col_q),
      .rd_data(rd_data[i])
    );
  end

  assign n_m1    = RW'(n_elems(BUFFD, mode_q) - 1);
  assign wr_last = wr_row_q == n_m1;
  assign ld_last = ld_col_q == n_m1;
  assign out_acc = out_vld_q && out_rdy;
  assign rel     = out_acc && out_last_q;
  // a bank whose final column is leaving this cycle may already take the next tile's first row
  assign fill_ok = bank_q[fill_sel_q] inside {B_EMPTY, B_FILL} || (rel && out_bank_q == fill_sel_q);
  assign in_rdy  = state_q == S_RUN && fill_ok && in_tiles_q != tnum_q;
  assign in_acc  = in_vld && in_rdy;
  assign ld_ok   = state_q == S_RUN && (!out_vld_q || out_rdy) && bank_q[ld_sel_q] inside {B_FULL, B_DRAIN};
  assign out_data = out_data_q;
  assign out_vld  = out_vld_q;
  assign busy     = state_q != S_IDLE;
  assign finish   = state_q == S_DONE;
  assign cfg_err  = cfg_err_q;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    tnum_d      = tnum_q;
    pend_d      = pend_q;
    cfg_err_d   = 1'b0;
    in_tiles_d  = in_tiles_q;
    out_tiles_d = out_tiles_q;
    fill_sel_d  = fill_sel_q;
    ld_sel_d    = ld_sel_q;
    wr_row_d    = wr_row_q;
    ld_col_d    = ld_col_q;
    bank_d      = bank_q;
    out_vld_d   = out_vld_q && !out_rdy;
    out_data_d  = out_data_q;
    out_bank_d  = out_bank_q;
    out_last_d  = out_last_q;
    if (state_q == S_IDLE && pend_q) begin
      pend_d  = 1'b0;
      state_d = S_DONE;
    end else if (state_q == S_IDLE && start) begin
      cfg_err_d = mode_e'(mode) == M_RSV;
      if (mode_e'(mode) != M_RSV) begin
        mode_d      = mode_e'(mode);
        tnum_d      = tile_num;
        in_tiles_d  = '0;
        out_tiles_d = '0;
        fill_sel_d  = 1'b0;
        ld_sel_d    = 1'b0;
        wr_row_d    = '0;
        ld_col_d    = '0;
        pend_d      = tile_num == '0;
        state_d     = tile_num == '0 ? S_IDLE : S_RUN;
      end
    end
    if (state_q == S_DONE) state_d = S_IDLE;
    if (rel) begin
      bank_d[out_bank_q] = B_EMPTY;
      out_tiles_d = out_tiles_q + 1'b1;
      if (out_tiles_d == tnum_q) state_d = S_DONE;
    end
    if (in_acc) begin
      bank_d[fill_sel_q] = wr_last ? B_FULL : B_FILL;
      wr_row_d   = wr_last ? '0 : wr_row_q + 1'b1;
      fill_sel_d = fill_sel_q ^ wr_last;
      in_tiles_d = in_tiles_q + CW'(wr_last);
    end
    if (ld_ok) begin
      out_vld_d        = 1'b1;
      out_data_d       = rd_data[ld_sel_q];
      out_bank_d       = ld_sel_q;
      out_last_d       = ld_last;
      bank_d[ld_sel_q] = B_DRAIN;
      ld_col_d         = ld_last ? '0 : ld_col_q + 1'b1;
      ld_sel_d         = ld_sel_q ^ ld_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mode_q      <= M_B1;
      tnum_q      <= '0;
      pend_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      in_tiles_q  <= '0;
      out_tiles_q <= '0;
      fill_sel_q  <= 1'b0;
      ld_sel_q    <= 1'b0;
      wr_row_q    <= '0;
      ld_col_q    <= '0;
      bank_q[0]   <= B_EMPTY;
      bank_q[1]   <= B_EMPTY;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_bank_q  <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      tnum_q      <= tnum_d;
      pend_q      <= pend_d;
      cfg_err_q   <= cfg_err_d;
      in_tiles_q  <= in_tiles_d;
      out_tiles_q <= out_tiles_d;
      fill_sel_q  <= fill_sel_d;
      ld_sel_q    <= ld_sel_d;
      wr_row_q    <= wr_row_d;
      ld_col_q    <= ld_col_d;
      bank_q      <= bank_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_bank_q  <= out_bank_d;
      out_last_q  <= out_last_d;
    end
  end
endmodule

// File: tb/tb_tile_transpose.sv
// tb_tile_transpose: table-driven jobs with a transpose scoreboard plus corner-case sequences
module tb_tile_transpose;
  localparam int BUFFD = 16, CW = 16, W = BUFFD*8;
  logic clk = 1'b0, reset, start, in_vld, in_rdy, out_vld, out_rdy, busy, finish, cfg_err;
  logic [1:0] mode;
  logic [CW-1:0] tile_num;
  logic [W-1:0] in_data, out_data;
  int errors = 0, checks = 0;
  logic [W-1:0] sb [$];

  typedef struct {
    logic [1:0] m;
    int tn, vp, rp, hold, inj;
    bit nobub;
    int exp_out;
  } job_t;
  job_t jobs [6];

  always #5 clk = ~clk;

  tile_transpose #(.BUFFD(BUFFD), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .tile_num(tile_num),
    .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .busy(busy), .finish(finish), .cfg_err(cfg_err)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_row();
    logic [W-1:0] v;
    for (int k = 0; k < W/32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // output row c, element r = input row r, element c (e bytes per element)
  function automatic logic [W-1:0] xpose_row(input logic [W-1:0] t [BUFFD], input int e, input int c);
    logic [W-1:0] o = '0;
    for (int r = 0; r < BUFFD/e; r++)
      for (int b = 0; b < e*8; b++) o[r*e*8 + b] = t[r][c*e*8 + b];
    return o;
  endfunction

  task automatic check_reset_outs(input string tag);
    check({tag, "_in_rdy"}, W'(in_rdy), '0);
    check({tag, "_out_vld"}, W'(out_vld), '0);
    check({tag, "_busy"}, W'(busy), '0);
    check({tag, "_finish"}, W'(finish), '0);
    check({tag, "_cfg_err"}, W'(cfg_err), '0);
    check({tag, "_out_data"}, out_data, '0);
  endtask

  task automatic run_job(input job_t j, input int ji);
    int n = BUFFD >> j.m, e = 1 << j.m, total = j.tn * (BUFFD >> j.m);
    int in_i = 0, outs = 0, fins = 0, cerr = 0, fin_cyc = -1, first_out = -1, last_out = -1;
    bit hold_v = 0;
    logic [W-1:0] hold_d, row;
    logic [W-1:0] rows [$];
    logic [W-1:0] t [BUFFD];
    for (int k = 0; k < j.tn; k++) begin
      for (int r = 0; r < BUFFD; r++) t[r] = '0;
      for (int r = 0; r < n; r++) begin
        for (int b = 0; b < BUFFD; b++) row[b*8 +: 8] = 8'(16*r + b + 64*k + 7*ji);
        t[r] = row;
        rows.push_back(row);
      end
      for (int c = 0; c < n; c++) sb.push_back(xpose_row(t, e, c));
    end
    @(posedge clk); #1;
    start = 1'b1; mode = j.m; tile_num = CW'(j.tn); in_vld = 1'b0; out_rdy = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        start = cyc == j.inj;
        mode = 2'($urandom);
        tile_num = CW'($urandom);
        in_vld = in_i < total && $urandom_range(99) < j.vp;
        in_data = in_vld ? rows[in_i] : rnd_row();
        out_rdy = cyc >= j.hold && $urandom_range(99) < j.rp;
      end
      @(negedge clk);
      if (j.hold > 0 && cyc == j.hold) begin
        check("hold_rows_in", W'(in_i), W'(total));
        check("hold_outs", W'(outs), '0);
        check("hold_in_rdy", W'(in_rdy), '0);
      end
      if (hold_v) begin
        check("stall_vld", W'(out_vld), W'(1));
        check("stall_data", out_data, hold_d);
      end
      hold_v = out_vld && !out_rdy;
      hold_d = out_data;
      if (cfg_err) cerr++;
      if (finish) begin
        fins++;
        if (fin_cyc < 0) fin_cyc = cyc;
      end
      if (in_vld && in_rdy) in_i++;
      if (out_vld && out_rdy) begin
        if (sb.size() == 0) check("sb_underflow", out_data, 'x);
        else check($sformatf("job%0d_row%0d", ji, outs), out_data, sb.pop_front());
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        outs++;
      end
      if (fin_cyc >= 0 && cyc >= fin_cyc + 2) break;
    end
    start = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    check($sformatf("job%0d_outs", ji), W'(outs), W'(j.exp_out));
    check($sformatf("job%0d_sb_left", ji), W'(sb.size()), '0);
    check($sformatf("job%0d_finishes", ji), W'(fins), W'(1));
    check($sformatf("job%0d_finish_cyc", ji), W'(fin_cyc), W'(last_out + 1));
    check($sformatf("job%0d_cfg_err", ji), W'(cerr), '0);
    check($sformatf("job%0d_busy_end", ji), W'(busy), '0);
    if (j.nobub) check($sformatf("job%0d_out_span", ji), W'(last_out - first_out + 1), W'(outs));
    sb.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    jobs[0] = '{2'd0, 1, 100, 100, 0, -1, 1'b0, 16};
    jobs[1] = '{2'd2, 3, 100, 100, 0, -1, 1'b1, 12};
    jobs[2] = '{2'd1, 2, 100, 100, 20, -1, 1'b0, 16};
    jobs[3] = '{2'd0, 2, 60, 50, 0, 6, 1'b0, 32};
    jobs[4] = '{2'd2, 5, 70, 70, 0, -1, 1'b0, 20};
    jobs[5] = '{2'd1, 3, 50, 80, 0, -1, 1'b0, 24};
    reset = 1'b1; start = 1'b0; mode = '0; tile_num = '0;
    in_vld = 1'b0; in_data = '0; out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outs("rst");
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) run_job(jobs[i], i);
    // reserved mode: error pulse only, no job
    @(posedge clk); #1 start = 1'b1; mode = 2'd3; tile_num = CW'(4);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("cfg_err_pulse", W'(cfg_err), W'(1));
    check("cfg_err_busy", W'(busy), '0);
    @(negedge clk);
    check("cfg_err_clear", W'(cfg_err), '0);
    check("cfg_err_idle", W'(busy), '0);
    // zero-tile job: finish two cycles after start, never ready
    @(posedge clk); #1 start = 1'b1; mode = 2'd0; tile_num = '0;
    @(posedge clk); #1 start = 1'b0; in_vld = 1'b1;
    @(negedge clk);
    check("zero_fin_c1", W'(finish), '0);
    check("zero_rdy_c1", W'(in_rdy), '0);
    @(negedge clk);
    check("zero_fin_c2", W'(finish), W'(1));
    check("zero_rdy_c2", W'(in_rdy), '0);
    @(negedge clk);
    check("zero_fin_c3", W'(finish), '0);
    in_vld = 1'b0;
    // reset in the middle of a tile, then a clean job
    @(posedge clk); #1 start = 1'b1; mode = 2'd0; tile_num = CW'(1);
    @(posedge clk); #1 start = 1'b0; in_vld = 1'b1; out_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = rnd_row();
      @(posedge clk); #1;
    end
    reset = 1'b1; in_vld = 1'b0;
    @(negedge clk);
    check("midrst_busy_before", W'(busy), W'(1));
    @(negedge clk);
    check_reset_outs("midrst");
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_no_finish", W'(finish), '0);
    run_job(jobs[0], 6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
